// File: rtl/alarm_ring_if.sv
// Alarm ring controller signal bundle: control inputs and status outputs.
interface alarm_ring_if;
    logic       tick_1hz;
    logic       match;
    logic       enable;
    logic       snooze_btn;
    logic       stop_btn;
    logic       ringing;
    logic       buzzer;
    logic       snoozing;
    logic [2:0] snooze_cnt;
    logic       done;

    modport master (
        output tick_1hz, match, enable, snooze_btn, stop_btn,
        input  ringing, buzzer, snoozing, snooze_cnt, done
    );

    modport slave (
        input  tick_1hz, match, enable, snooze_btn, stop_btn,
        output ringing, buzzer, snoozing, snooze_cnt, done
    );
endinterface

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring/snooze sequencer with a seconds down-counter.
// All outputs come straight from flops loaded with next-state values.
module alarm_ring_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    alarm_ring_if.slave   bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RING   = 2'd1;
    localparam logic [1:0] S_SNOOZE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [8:0] LP_RING   = 9'(RING_SEC);
    localparam logic [8:0] LP_SNOOZE = 9'(SNOOZE_SEC);
    localparam logic [2:0] LP_MAX    = 3'(MAX_SNOOZE);

    logic [1:0] r_state;
    logic [8:0] r_timer;
    logic       r_beat;
    logic       r_match_d;
    logic [2:0] r_cnt;
    logic       r_ringing;
    logic       r_buzzer;
    logic       r_snoozing;
    logic       r_done;

    logic [1:0] w_state_nxt;
    logic [8:0] w_timer_nxt;
    logic [8:0] w_timer_dec;
    logic       w_beat_nxt;
    logic [2:0] w_cnt_nxt;
    logic       w_trig;
    logic       w_expire;
    logic       w_snz_ok;

    assign w_trig      = bus.match & ~r_match_d & bus.enable;
    assign w_expire    = bus.tick_1hz & (r_timer == 9'd1);
    assign w_snz_ok    = bus.snooze_btn & (r_cnt < LP_MAX);
    assign w_timer_dec = (r_timer != 9'd0) ? r_timer - 9'd1 : 9'd0;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_beat_nxt  = r_beat;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_state_nxt = S_RING;
                    w_timer_nxt = LP_RING;
                    w_beat_nxt  = 1'b1;
                end
            end
            S_RING: begin
                if (!bus.enable) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = 9'd0;
                    w_beat_nxt  = 1'b0;
                    w_cnt_nxt   = 3'd0;
                end else if (bus.stop_btn || w_expire) begin
                    w_state_nxt = S_DONE;
                    w_timer_nxt = 9'd0;
                    w_beat_nxt  = 1'b0;
                    w_cnt_nxt   = 3'd0;
                end else if (w_snz_ok) begin
                    w_state_nxt = S_SNOOZE;
                    w_timer_nxt = LP_SNOOZE;
                    w_cnt_nxt   = r_cnt + 3'd1;
                end else if (bus.tick_1hz) begin
                    w_timer_nxt = w_timer_dec;
                    w_beat_nxt  = ~r_beat;
                end
            end
            S_SNOOZE: begin
                if (!bus.enable) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = 9'd0;
                    w_beat_nxt  = 1'b0;
                    w_cnt_nxt   = 3'd0;
                end else if (bus.stop_btn) begin
                    w_state_nxt = S_DONE;
                    w_timer_nxt = 9'd0;
                    w_beat_nxt  = 1'b0;
                    w_cnt_nxt   = 3'd0;
                end else if (w_expire) begin
                    w_state_nxt = S_RING;
                    w_timer_nxt = LP_RING;
                    w_beat_nxt  = 1'b1;
                end else if (bus.tick_1hz) begin
                    w_timer_nxt = w_timer_dec;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = 9'd0;
                w_beat_nxt  = 1'b0;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= 9'd0;
            r_beat     <= 1'b0;
            r_match_d  <= 1'b0;
            r_cnt      <= 3'd0;
            r_ringing  <= 1'b0;
            r_buzzer   <= 1'b0;
            r_snoozing <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_beat     <= w_beat_nxt;
            r_match_d  <= bus.match;
            r_cnt      <= w_cnt_nxt;
            r_ringing  <= (w_state_nxt == S_RING);
            r_buzzer   <= (w_state_nxt == S_RING) & w_beat_nxt;
            r_snoozing <= (w_state_nxt == S_SNOOZE);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.ringing    = r_ringing;
    assign bus.buzzer     = r_buzzer;
    assign bus.snoozing   = r_snoozing;
    assign bus.snooze_cnt = r_cnt;
    assign bus.done       = r_done;
endmodule
